pd_axis_sched: RTL and testbench

Time-multiplexes one shared PD math engine across the three flight axes: pitch, roll and yaw. The engine keeps a banked derivative history per axis, selected by `pd_axis`. On each new inertial sample, the scheduler steps through the axes in turn. For each axis it drives the engine's desired/actual inputs, pulses the engine's valid, and captures `pterm`/`dterm`. When all three axes are done, it publishes a coherent set of results to the flight controller with a one-cycle `done` pulse.

---
 rtl/pd_axis_sched_if.sv | 45 ++++
 rtl/pd_axis_sched.sv | 168 ++++++++++++++++
 tb/tb_pd_axis_sched.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pd_axis_sched_if.sv
// Bus bundle for the PD axis scheduler: inertial sample in, shared PD engine port, published results out.
// vld is a one-cycle qualifier with no back-pressure: a sample is taken in every cycle vld is high.
interface pd_axis_sched_if;
    logic        vld;
    logic [15:0] d_ptch;
    logic [15:0] d_roll;
    logic [15:0] d_yaw;
    logic [15:0] ptch;
    logic [15:0] roll;
    logic [15:0] yaw;

    logic [15:0] pd_desired;
    logic [15:0] pd_actual;
    logic        pd_vld;
    logic [1:0]  pd_axis;
    logic [9:0]  pd_pterm;
    logic [11:0] pd_dterm;

    logic [9:0]  ptch_pterm;
    logic [9:0]  roll_pterm;
    logic [9:0]  yaw_pterm;
    logic [11:0] ptch_dterm;
    logic [11:0] roll_dterm;
    logic [11:0] yaw_dterm;
    logic        done;
    logic        busy;

    modport slave (
        input  vld, d_ptch, d_roll, d_yaw, ptch, roll, yaw,
        input  pd_pterm, pd_dterm,
        output pd_desired, pd_actual, pd_vld, pd_axis,
        output ptch_pterm, roll_pterm, yaw_pterm,
        output ptch_dterm, roll_dterm, yaw_dterm,
        output done, busy
    );

    modport master (
        output vld, d_ptch, d_roll, d_yaw, ptch, roll, yaw,
        output pd_pterm, pd_dterm,
        input  pd_desired, pd_actual, pd_vld, pd_axis,
        input  ptch_pterm, roll_pterm, yaw_pterm,
        input  ptch_dterm, roll_dterm, yaw_dterm,
        input  done, busy
    );
endinterface

// File: rtl/pd_axis_sched.sv
// Time-multiplexes one PD engine over pitch/roll/yaw per inertial sample and publishes
// all six results together with a one-cycle done pulse.
module pd_axis_sched #(
    parameter int NUM_AXES = 3
) (
    input  logic             clk,
    input  logic             rst,
    pd_axis_sched_if.slave   sched,
    output logic [2:0]       dbg_state_o
);
    localparam logic [1:0] LAST_AXIS = 2'(NUM_AXES - 1);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        SET  = 3'd1,
        STEP = 3'd2,
        CAPD = 3'd3,
        DONE = 3'd4
    } state_e;

    state_e            state_q, state_d;
    logic [1:0]        axis_q, axis_d;
    logic              pend_q, pend_d;
    logic              start;
    logic              active_d;

    logic [2:0][15:0]  bus_des, bus_act;
    logic [2:0][15:0]  smp_des_q, smp_act_q;
    logic [2:0][15:0]  snap_des_q, snap_act_q;
    logic [2:0][15:0]  snap_des_d, snap_act_d;

    logic [2:0][9:0]   stg_p_q;
    logic [1:0][11:0]  stg_d_q;
    logic [2:0][9:0]   pub_p_q;
    logic [2:0][11:0]  pub_d_q;

    logic [15:0]       pd_desired_q, pd_actual_q;
    logic [1:0]        pd_axis_q;
    logic              pd_vld_q, done_q, busy_q;

    assign bus_des = {sched.d_yaw, sched.d_roll, sched.d_ptch};
    assign bus_act = {sched.yaw, sched.roll, sched.ptch};

    always_comb begin
        state_d = state_q;
        axis_d  = axis_q;
        start   = 1'b0;
        case (state_q)
            IDLE: begin
                if (sched.vld) begin
                    state_d = SET;
                    axis_d  = 2'd0;
                    start   = 1'b1;
                end
            end
            SET:  state_d = STEP;
            STEP: state_d = CAPD;
            CAPD: begin
                if (axis_q == LAST_AXIS) begin
                    state_d = DONE;
                end else begin
                    state_d = SET;
                    axis_d  = axis_q + 2'd1;
                end
            end
            DONE: begin
                axis_d = 2'd0;
                if (pend_q || sched.vld) begin
                    state_d = SET;
                    start   = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                axis_d  = 2'd0;
            end
        endcase
    end

    // A run started by a fresh vld takes the bus directly; a pending run takes the latest sample.
    always_comb begin
        snap_des_d = snap_des_q;
        snap_act_d = snap_act_q;
        if (start) begin
            snap_des_d = sched.vld ? bus_des : smp_des_q;
            snap_act_d = sched.vld ? bus_act : smp_act_q;
        end
    end

    always_comb begin
        pend_d = pend_q;
        if (start) begin
            pend_d = 1'b0;
        end else if (sched.vld && (state_q != IDLE)) begin
            pend_d = 1'b1;
        end
    end

    assign active_d = (state_d == SET) || (state_d == STEP) || (state_d == CAPD);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            axis_q       <= '0;
            pend_q       <= 1'b0;
            smp_des_q    <= '0;
            smp_act_q    <= '0;
            snap_des_q   <= '0;
            snap_act_q   <= '0;
            stg_p_q      <= '0;
            stg_d_q      <= '0;
            pub_p_q      <= '0;
            pub_d_q      <= '0;
            pd_desired_q <= '0;
            pd_actual_q  <= '0;
            pd_axis_q    <= '0;
            pd_vld_q     <= 1'b0;
            done_q       <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            axis_q     <= axis_d;
            pend_q     <= pend_d;
            snap_des_q <= snap_des_d;
            snap_act_q <= snap_act_d;
            if (sched.vld) begin
                smp_des_q <= bus_des;
                smp_act_q <= bus_act;
            end

            pd_vld_q     <= (state_d == STEP);
            done_q       <= (state_d == DONE);
            busy_q       <= (state_d != IDLE);
            pd_axis_q    <= active_d ? axis_d : 2'd0;
            pd_desired_q <= active_d ? snap_des_d[axis_d] : 16'd0;
            pd_actual_q  <= active_d ? snap_act_d[axis_d] : 16'd0;

            if (state_q == STEP) begin
                stg_p_q[axis_q] <= sched.pd_pterm;
            end
            // Yaw D is only valid in the last CAPD cycle, so it bypasses staging on publish.
            if (state_q == CAPD) begin
                if (axis_q != LAST_AXIS) begin
                    stg_d_q[axis_q[0]] <= sched.pd_dterm;
                end else begin
                    pub_p_q <= stg_p_q;
                    pub_d_q <= {sched.pd_dterm, stg_d_q};
                end
            end
        end
    end

    assign sched.pd_desired = pd_desired_q;
    assign sched.pd_actual  = pd_actual_q;
    assign sched.pd_axis    = pd_axis_q;
    assign sched.pd_vld     = pd_vld_q;
    assign sched.done       = done_q;
    assign sched.busy       = busy_q;
    assign sched.ptch_pterm = pub_p_q[0];
    assign sched.roll_pterm = pub_p_q[1];
    assign sched.yaw_pterm  = pub_p_q[2];
    assign sched.ptch_dterm = pub_d_q[0];
    assign sched.roll_dterm = pub_d_q[1];
    assign sched.yaw_dterm  = pub_d_q[2];
    assign dbg_state_o      = state_q;
endmodule

// File: tb/tb_pd_axis_sched.sv
// Directed bench for pd_axis_sched with a timing-strict PD engine model
// (pterm only while pd_vld is high, dterm only the cycle after).
module tb_pd_axis_sched;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pd_axis_sched_if bus_if();
    logic [2:0] dbg_state;

    pd_axis_sched #(.NUM_AXES(3)) dut (
        .clk         (clk),
        .rst         (rst),
        .sched       (bus_if),
        .dbg_state_o (dbg_state)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [9:0]  p_base   = 10'd0;
    logic [11:0] d_base   = 12'd0;
    logic        axis_add = 1'b0;
    logic [1:0]  a1 = 2'd0, a2 = 2'd0;
    logic        v1 = 1'b0;

    always @(posedge clk) begin
        a1 <= bus_if.pd_axis;
        a2 <= a1;
        v1 <= bus_if.pd_vld;
    end
    assign bus_if.pd_pterm = bus_if.pd_vld ? p_base + (axis_add ? {8'd0, a1} : 10'd0) : 10'h3FF;
    assign bus_if.pd_dterm = v1 ? d_base + (axis_add ? {10'd0, a2} : 12'd0) : 12'hFFF;

    logic [2:0][9:0]  exp_p;
    logic [2:0][11:0] exp_d;
    logic [2:0][9:0]  pub_p;
    logic [2:0][11:0] pub_d;
    assign pub_p = {bus_if.yaw_pterm, bus_if.roll_pterm, bus_if.ptch_pterm};
    assign pub_d = {bus_if.yaw_dterm, bus_if.roll_dterm, bus_if.ptch_dterm};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_pub(input string tag);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("%s_pterm%0d", tag, i), 64'(pub_p[i]), 64'(exp_p[i]));
            check($sformatf("%s_dterm%0d", tag, i), 64'(pub_d[i]), 64'(exp_d[i]));
        end
    endtask

    task automatic set_bus(input logic [2:0][15:0] dv, input logic [2:0][15:0] av);
        bus_if.d_ptch = dv[0];
        bus_if.d_roll = dv[1];
        bus_if.d_yaw  = dv[2];
        bus_if.ptch   = av[0];
        bus_if.roll   = av[1];
        bus_if.yaw    = av[2];
    endtask

    task automatic scramble_bus();
        logic [2:0][15:0] r1, r2;
        for (int i = 0; i < 3; i++) begin
            r1[i] = 16'($urandom_range(0, 65535));
            r2[i] = 16'($urandom_range(0, 65535));
        end
        set_bus(r1, r2);
    endtask

    task automatic set_expected(input logic [9:0] pb, input logic [11:0] db, input logic add);
        for (int i = 0; i < 3; i++) begin
            exp_p[i] = pb + (add ? 10'(i) : 10'd0);
            exp_d[i] = db + (add ? 12'(i) : 12'd0);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"}, 64'(bus_if.busy), 64'd0);
        check({tag, "_done"}, 64'(bus_if.done), 64'd0);
        check({tag, "_pd_vld"}, 64'(bus_if.pd_vld), 64'd0);
        check({tag, "_pd_axis"}, 64'(bus_if.pd_axis), 64'd0);
        check({tag, "_pd_desired"}, 64'(bus_if.pd_desired), 64'd0);
        check({tag, "_pd_actual"}, 64'(bus_if.pd_actual), 64'd0);
        check({tag, "_state"}, 64'(dbg_state), 64'd0);
    endtask

    // One isolated run from IDLE: vld sampled at edge E, observed after edges E..E+10.
    task automatic do_run(input string tag, input logic [2:0][15:0] dv, input logic [2:0][15:0] av,
                          input logic [9:0] pb, input logic [11:0] db, input logic add);
        set_bus(dv, av);
        p_base = pb;
        d_base = db;
        axis_add = add;
        bus_if.vld = 1'b1;
        @(posedge clk);
        for (int k = 0; k <= 10; k++) begin
            logic exp_v;
            @(negedge clk);
            bus_if.vld = 1'b0;
            if (k == 0) scramble_bus();
            exp_v = (k % 3 == 1) && (k < 9);
            check({tag, "_pd_vld"}, 64'(bus_if.pd_vld), 64'(exp_v));
            check({tag, "_done"}, 64'(bus_if.done), 64'(k == 9));
            check({tag, "_busy"}, 64'(bus_if.busy), 64'(k <= 9));
            if (exp_v) begin
                check({tag, "_pd_axis"}, 64'(bus_if.pd_axis), 64'(k / 3));
                check({tag, "_pd_desired"}, 64'(bus_if.pd_desired), 64'(dv[k / 3]));
                check({tag, "_pd_actual"}, 64'(bus_if.pd_actual), 64'(av[k / 3]));
            end
            if (k == 0 || k == 8) check_pub({tag, "_hold"});
            if (k == 9) begin
                check({tag, "_done_operand"}, 64'(bus_if.pd_desired), 64'd0);
                set_expected(pb, db, add);
                check_pub({tag, "_new"});
            end
        end
    endtask

    function automatic logic [15:0] cdes(input int m, input int i);
        return 16'(4096 + m * 8 + i);
    endfunction

    function automatic logic [15:0] cact(input int m, input int i);
        return 16'(32768 + m * 8 + i);
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0][15:0] dv, av, dx0, ax0, dva, ava, dvb, avb;
        int dn, pv, snap_m;
        logic prev_v;

        // Reset with vld raised alongside: vld must be ignored.
        rst = 1'b1;
        bus_if.vld = 1'b1;
        set_bus({16'h1111, 16'h2222, 16'h3333}, {16'h4444, 16'h5555, 16'h6666});
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        bus_if.vld = 1'b0;
        exp_p = '0;
        exp_d = '0;
        check_idle_outputs("reset");
        check_pub("reset");
        @(negedge clk);
        check_idle_outputs("post_reset");

        // Single run with the documented operand set.
        dv = {16'hFFF0, 16'h0000, 16'h0100};
        av = {16'h0000, 16'h0010, 16'h0080};
        do_run("single", dv, av, 10'd1, 12'h010, 1'b1);

        // Second run: prior results must hold until the new set lands.
        dv = {16'h1234, 16'h8001, 16'h7FFE};
        av = {16'hABCD, 16'h0F0F, 16'h5A5A};
        do_run("coherent", dv, av, 10'd5, 12'h020, 1'b1);

        // Coalescing: vld at E, E+3 (A) and E+6 (B); one extra run using B.
        dx0 = {16'h0003, 16'h0002, 16'h0001};
        ax0 = {16'h0013, 16'h0012, 16'h0011};
        dva = {16'hA003, 16'hA002, 16'hA001};
        ava = {16'hA013, 16'hA012, 16'hA011};
        dvb = {16'hB003, 16'hB002, 16'hB001};
        avb = {16'hB013, 16'hB012, 16'hB011};
        set_bus(dx0, ax0);
        p_base = 10'h040;
        d_base = 12'h100;
        axis_add = 1'b1;
        bus_if.vld = 1'b1;
        dn = 0;
        pv = 0;
        @(posedge clk);
        for (int k = 0; k <= 21; k++) begin
            int r;
            logic exp_v, live;
            @(negedge clk);
            bus_if.vld = (k == 2) || (k == 5);
            if (k == 2) set_bus(dva, ava);
            else if (k == 5) set_bus(dvb, avb);
            else if (k > 0) scramble_bus();
            r = (k < 10) ? k : k - 10;
            live = (k <= 19);
            exp_v = live && (r % 3 == 1) && (r < 9);
            if (bus_if.done) dn++;
            if (bus_if.pd_vld) pv++;
            check("coal_busy", 64'(bus_if.busy), 64'(live));
            check("coal_done", 64'(bus_if.done), 64'(live && r == 9));
            check("coal_pd_vld", 64'(bus_if.pd_vld), 64'(exp_v));
            if (exp_v) begin
                check("coal_pd_axis", 64'(bus_if.pd_axis), 64'(r / 3));
                check("coal_pd_desired", 64'(bus_if.pd_desired), 64'(k < 10 ? dx0[r / 3] : dvb[r / 3]));
                check("coal_pd_actual", 64'(bus_if.pd_actual), 64'(k < 10 ? ax0[r / 3] : avb[r / 3]));
            end
            if (k == 19) begin
                set_expected(10'h040, 12'h100, 1'b1);
                check_pub("coal");
            end
        end
        check("coal_done_count", 64'(dn), 64'd2);
        check("coal_pd_vld_count", 64'(pv), 64'd6);

        // Continuous vld for 40 edges: done every 10 cycles, last run from the pending sample.
        for (int i = 0; i < 3; i++) begin
            dv[i] = cdes(0, i);
            av[i] = cact(0, i);
        end
        set_bus(dv, av);
        p_base = 10'h0A0;
        d_base = 12'h300;
        bus_if.vld = 1'b1;
        dn = 0;
        prev_v = 1'b0;
        @(posedge clk);
        for (int k = 0; k <= 51; k++) begin
            int r;
            logic exp_v, live;
            @(negedge clk);
            r = k % 10;
            live = (k <= 49);
            exp_v = live && (r % 3 == 1) && (r < 9);
            snap_m = (k / 10 < 4) ? (k / 10) * 10 : 39;
            if (bus_if.done) dn++;
            check("cont_busy", 64'(bus_if.busy), 64'(live));
            check("cont_done", 64'(bus_if.done), 64'(live && r == 9));
            check("cont_pd_vld", 64'(bus_if.pd_vld), 64'(exp_v));
            check("cont_pd_vld_gap", 64'(bus_if.pd_vld && prev_v), 64'd0);
            if (exp_v) begin
                check("cont_pd_desired", 64'(bus_if.pd_desired), 64'(cdes(snap_m, r / 3)));
                check("cont_pd_actual", 64'(bus_if.pd_actual), 64'(cact(snap_m, r / 3)));
            end
            prev_v = bus_if.pd_vld;
            for (int i = 0; i < 3; i++) begin
                dv[i] = cdes(k + 1, i);
                av[i] = cact(k + 1, i);
            end
            set_bus(dv, av);
            bus_if.vld = (k < 39);
        end
        check("cont_done_count", 64'(dn), 64'd5);
        set_expected(10'h0A0, 12'h300, 1'b1);
        check_pub("cont");

        // Reset mid-run at edge E+5: no done, outputs cleared, no further pd_vld.
        set_bus({16'h7777, 16'h6666, 16'h5555}, {16'h4444, 16'h3333, 16'h2222});
        bus_if.vld = 1'b1;
        @(posedge clk);
        for (int k = 0; k <= 20; k++) begin
            @(negedge clk);
            bus_if.vld = 1'b0;
            rst = (k == 4);
            if (k == 5) begin
                exp_p = '0;
                exp_d = '0;
                check_idle_outputs("midrst");
                check_pub("midrst");
            end else if (k > 5) begin
                check("midrst_pd_vld", 64'(bus_if.pd_vld), 64'd0);
                check("midrst_done", 64'(bus_if.done), 64'd0);
            end
        end

        // Pass-through of extreme values without sign alteration.
        dv = {16'hFFFF, 16'h8000, 16'h7FFF};
        av = {16'h7FFF, 16'h0001, 16'h8000};
        do_run("extreme", dv, av, 10'h200, 12'h800, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
